// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory boot loader.
package imem_pkg;

   localparam int IMEM_BYTES  = 512;
   localparam int IMEM_ADDR_W = 9;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   // Largest word count that fits in the instruction memory.
   function automatic int max_words(input int mem_bytes);
      return mem_bytes / 4;
   endfunction

endpackage

// File: rtl/imem_write_port.sv
// Registered byte-write stage into instruction memory.
// Latency 1 cycle; no backpressure, address/data hold while idle.
module imem_write_port
   import imem_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_vld,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_dat,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= wr_vld;
         if (wr_vld) begin
            mem_addr  <= wr_addr;
            mem_wdata <= wr_dat;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte frame into big-endian imem; IMEM_LOADER_CHECKSUM_EN adds XOR trailer.
// Writes land one cycle after acceptance; in_ready is a function of state only, in_valid low simply stalls.
module imem_loader
   import imem_pkg::*;
#(
   parameter int MEM_BYTES = IMEM_BYTES,
   parameter int ADDR_W    = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-2:0] words_loaded
);

   localparam logic [16:0] MAX_WORDS = 17'(max_words(MEM_BYTES));

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = CSUM;
   localparam state_t AFTER_ZERO = CSUM;
`else
   localparam state_t AFTER_DATA = DONE;
   localparam state_t AFTER_ZERO = DONE;
`endif

   state_t            state_q, state_d;
   logic [7:0]        len_hi_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] last_ptr_q;
   logic [ADDR_W-2:0] words_q;
   logic              start_load;
   logic              wr_vld;
   logic [15:0]       nwords;
   logic [ADDR_W-1:0] last_ptr_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   assign nwords       = {len_hi_q, in_data};
   // Only meaningful once the length check has passed, so truncation is safe.
   assign last_ptr_d   = ADDR_W'({nwords, 2'b00} - 18'd1);
   assign words_loaded = words_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      start_load = 1'b0;
      wr_vld     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_load = 1'b1;
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_d = LEN_LO;
         end
         LEN_LO: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               if (nwords == 16'd0)                 state_d = AFTER_ZERO;
               else if ({1'b0, nwords} > MAX_WORDS) state_d = ERR;
               else                                 state_d = DATA;
            end
         end
         DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               wr_vld = 1'b1;
               if (ptr_q == last_ptr_q) state_d = AFTER_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_d = (in_data == csum_q) ? DONE : ERR;
         end
`endif
         DONE: begin
            done = 1'b1;
            if (start) begin
               start_load = 1'b1;
               state_d    = LEN_HI;
            end
         end
         ERR: begin
            error = 1'b1;
            if (start) begin
               start_load = 1'b1;
               state_d    = LEN_HI;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_hi_q   <= '0;
         last_ptr_q <= '0;
         ptr_q      <= '0;
         words_q    <= '0;
      end else begin
         if (start_load) begin
            ptr_q   <= '0;
            words_q <= '0;
         end
         if (state_q == LEN_HI && in_valid) len_hi_q   <= in_data;
         if (state_q == LEN_LO && in_valid) last_ptr_q <= last_ptr_d;
         if (wr_vld) begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q[1:0] == 2'b11) words_q <= words_q + 1'b1;
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             csum_q <= '0;
      else if (start_load) csum_q <= '0;
      else if (wr_vld)     csum_q <= csum_q ^ in_data;
   end
`endif

   imem_write_port #(
      .ADDR_W(ADDR_W)
   ) u_write_port (
      .clk       (clk),
      .rst       (rst),
      .wr_vld    (wr_vld),
      .wr_addr   (ptr_q),
      .wr_dat    (in_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at acceptance, monitor checks each mem_we.
module tb_imem_loader;

   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    in_data = 8'h00;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW-2:0] words_loaded;

   imem_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    dat;
      int            tag;
   } wr_t;

   wr_t         expq[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          writes = 0;
   logic [AW-1:0] nxt_addr = '0;
   logic [7:0]  tmem [512];
   logic [31:0] prog [8];

   always @(posedge clk) cyc = cyc + 1;
   always @(posedge clk) if (mem_we) tmem[mem_addr] <= mem_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest outstanding accepted data byte.
   always @(negedge clk) begin
      wr_t e;
      if (!rst && mem_we) begin
         writes++;
         if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0d data %h with no byte outstanding", mem_addr, mem_wdata);
         end else begin
            e = expq.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_data", 32'(mem_wdata), 32'(e.dat));
            chk("wr_latency_cycle", 32'(cyc), 32'(e.tag));
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input bit is_data, input int gaps);
      int t;
      repeat (gaps) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: in_ready stayed 0 for byte %h, required 1", d);
      end else if (is_data) begin
         expq.push_back('{nxt_addr, d, cyc + 1});
         nxt_addr++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nxt_addr = '0;
      writes   = 0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_words_clear", 32'(words_loaded), 32'd0);
      chk("start_done_clear", 32'(done), 32'd0);
      chk("start_error_clear", 32'(error), 32'd0);
   endtask

   task automatic wait_end();
      int t;
      t = 0;
      while (!(done || error) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!(done || error)) begin
         tests++;
         fails++;
         $display("FAIL end_timeout: done=%0d error=%0d, required one of them 1", done, error);
      end
      chk("end_busy_low", 32'(busy), 32'd0);
      chk("end_in_ready_low", 32'(in_ready), 32'd0);
   endtask

   task automatic drain_check(input int exp_writes);
      repeat (2) @(negedge clk);
      #1;
      chk("pending_writes", 32'(expq.size()), 32'd0);
      chk("write_count", 32'(writes), 32'(exp_writes));
   endtask

   task automatic load_prog(input int gaps);
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'h08, 1'b0, 0);
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 4; j++) begin
            b = prog[i][31-8*j -: 8];
            x = x ^ b;
            send_byte(b, 1'b1, (i == 0 && j == 0) ? 0 : gaps);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(x, 1'b0, 0);
`endif
   endtask

   task automatic check_prog();
      chk("done_after_load", 32'(done), 32'd1);
      chk("error_after_load", 32'(error), 32'd0);
      chk("words_loaded_8", 32'(words_loaded), 32'd8);
      chk("mem_word_pc0", {tmem[0], tmem[1], tmem[2], tmem[3]}, 32'h24010001);
      chk("mem_word_pc28", {tmem[28], tmem[29], tmem[30], tmem[31]}, 32'h1000FFFF);
      chk("mem_addr_hold", 32'(mem_addr), 32'd31);
   endtask

   initial begin
      prog[0] = 32'h24010001; prog[1] = 32'h24020002; prog[2] = 32'h00221820; prog[3] = 32'hAC030000;
      prog[4] = 32'h8C040004; prog[5] = 32'h00000000; prog[6] = 32'h00000000; prog[7] = 32'h1000FFFF;
      for (int i = 0; i < 512; i++) tmem[i] = 8'hxx;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);

      // 8-word load, in_valid held high
      do_start();
      load_prog(0);
      wait_end();
      drain_check(32);
      check_prog();

      // Same image under back-pressure (1,0,0,1 valid pattern)
      for (int i = 0; i < 32; i++) tmem[i] = 8'hxx;
      do_start();
      load_prog(2);
      wait_end();
      drain_check(32);
      check_prog();

      // Oversize length: 129 words
      do_start();
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'h81, 1'b0, 0);
      wait_end();
      chk("oversize_error", 32'(error), 32'd1);
      chk("oversize_done", 32'(done), 32'd0);
      drain_check(0);

      // Zero length
      do_start();
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'h00, 1'b0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h00, 1'b0, 0);
`endif
      wait_end();
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_error", 32'(error), 32'd0);
      chk("zero_words", 32'(words_loaded), 32'd0);
      drain_check(0);

      // Maximum length (128 words) is accepted, then reset after 5 data bytes
      do_start();
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'h80, 1'b0, 0);
      @(negedge clk);
      chk("max_len_in_ready", 32'(in_ready), 32'd1);
      chk("max_len_error", 32'(error), 32'd0);
      for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1, 0);
      @(negedge clk);
      chk("partial_words", 32'(words_loaded), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_mem_we", 32'(mem_we), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_words", 32'(words_loaded), 32'd0);
      chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
      chk("midrst_pending", 32'(expq.size()), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) tmem[i] = 8'hxx;
      do_start();
      load_prog(0);
      wait_end();
      drain_check(32);
      check_prog();

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum good: 12^34^56^78 = 08
      do_start();
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'h01, 1'b0, 0);
      send_byte(8'h12, 1'b1, 0);
      send_byte(8'h34, 1'b1, 0);
      send_byte(8'h56, 1'b1, 0);
      send_byte(8'h78, 1'b1, 0);
      send_byte(8'h08, 1'b0, 0);
      wait_end();
      chk("csum_good_done", 32'(done), 32'd1);
      drain_check(4);

      // Checksum bad
      do_start();
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'h01, 1'b0, 0);
      send_byte(8'h12, 1'b1, 0);
      send_byte(8'h34, 1'b1, 0);
      send_byte(8'h56, 1'b1, 0);
      send_byte(8'h78, 1'b1, 0);
      send_byte(8'h09, 1'b0, 0);
      wait_end();
      chk("csum_bad_error", 32'(error), 32'd1);
      chk("csum_bad_done", 32'(done), 32'd0);
      drain_check(4);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
